muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : muldiv_pkg                                                 |
// | Description : Operation encodings and FSM state type shared by the       |
// |               iterative multiply/divide unit.                            |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : muldiv_unit                                                |
// | Description : Iterative radix-2 multiply/divide unit writing HI/LO.      |
// |               Multiply and divide share one 2W shift register and one    |
// |               W+1-bit adder/subtractor; signs are fixed up at the end.   |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [1:0]            op,
   input  logic                  start,
   input  logic                  hi_we,
   input  logic                  lo_we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] c_LAST_CNT = CW'(DATA_WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [2*W-1:0]   r_acc;       // multiply: {partial, multiplier}; divide: {remainder, dividend}
   logic [W-1:0]     r_opnd;      // multiplicand magnitude or divisor magnitude
   logic [W-1:0]     r_a_orig;    // unmodified dividend, returned in HI on divide by zero
   logic [1:0]       r_op;
   logic             r_neg_lo;    // negate product / quotient at fix-up
   logic             r_neg_hi;    // negate remainder at fix-up
   logic             r_bzero;
   logic             r_busy;
   logic             r_done;
   logic [W-1:0]     r_hi;
   logic [W-1:0]     r_lo;

   logic             w_in_signed;
   logic             w_in_div;
   logic [W-1:0]     w_a_mag;
   logic [W-1:0]     w_b_mag;
   logic             w_run_div;
   logic [W:0]       w_lhs;
   logic [W:0]       w_rhs;
   logic             w_cin;
   logic [W:0]       w_sum;
   logic [2*W-1:0]   w_acc_step;
   logic [2*W-1:0]   w_prod;
   logic [W-1:0]     w_quo;
   logic [W-1:0]     w_rem;
   logic [W-1:0]     w_fix_hi;
   logic [W-1:0]     w_fix_lo;

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

   // Operand decode at accept: magnitudes for signed ops, raw values otherwise.
   always_comb begin
      w_in_signed = (op == OP_MULT) || (op == OP_DIV);
      w_in_div    = (op == OP_DIVU) || (op == OP_DIV);
      w_a_mag     = (w_in_signed && a[W-1]) ? (~a + 1'b1) : a;
      w_b_mag     = (w_in_signed && b[W-1]) ? (~b + 1'b1) : b;
   end

   // One radix-2 step through the shared adder: shift-add or restoring shift-subtract.
   always_comb begin
      w_run_div = (r_op == OP_DIVU) || (r_op == OP_DIV);
      w_lhs     = {1'b0, r_acc[2*W-1:W]};
      w_rhs     = r_acc[0] ? {1'b0, r_opnd} : '0;
      w_cin     = 1'b0;
      if (w_run_div) begin
         w_lhs = r_acc[2*W-1:W-1];
         w_rhs = ~{1'b0, r_opnd};
         w_cin = 1'b1;
      end
      w_sum = w_lhs + w_rhs + {{W{1'b0}}, w_cin};
      if (w_run_div) begin
         // A negative trial difference means the divisor did not fit: keep the shifted remainder.
         w_acc_step = w_sum[W] ? {r_acc[2*W-2:0], 1'b0}
                               : {w_sum[W-1:0], r_acc[W-2:0], 1'b1};
      end else begin
         w_acc_step = {w_sum, r_acc[W-1:1]};
      end
   end

   // Sign fix-up and divide-by-zero override for the HI/LO writeback.
   always_comb begin
      w_prod = r_neg_lo ? (~r_acc + 1'b1) : r_acc;
      w_quo  = r_neg_lo ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
      w_rem  = r_neg_hi ? (~r_acc[2*W-1:W] + 1'b1) : r_acc[2*W-1:W];
      w_fix_hi = w_prod[2*W-1:W];
      w_fix_lo = w_prod[W-1:0];
      if (w_run_div) begin
         w_fix_hi = r_bzero ? r_a_orig : w_rem;
         w_fix_lo = r_bzero ? '1 : w_quo;
      end
   end

   // Next-state logic: accept, iterate DATA_WIDTH steps, one fix-up cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (r_cnt == c_LAST_CNT) w_state_nxt = FIX;
         FIX:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Datapath, HI/LO and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_a_orig <= '0;
         r_op     <= OP_MULTU;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_bzero  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= (r_state == FIX);
         case (r_state)
            IDLE: begin
               if (hi_we) r_hi <= wdata;
               if (lo_we) r_lo <= wdata;
               if (start) begin
                  r_op     <= op;
                  r_cnt    <= '0;
                  r_a_orig <= a;
                  r_bzero  <= (b == '0);
                  r_neg_lo <= w_in_signed && (a[W-1] ^ b[W-1]);
                  r_neg_hi <= (op == OP_DIV) && a[W-1];
                  r_opnd   <= w_in_div ? w_b_mag : w_a_mag;
                  r_acc    <= {{W{1'b0}}, (w_in_div ? w_a_mag : w_b_mag)};
               end
            end
            RUN: begin
               r_acc <= w_acc_step;
               r_cnt <= (r_cnt == c_LAST_CNT) ? '0 : r_cnt + 1'b1;
            end
            FIX: begin
               r_hi <= w_fix_hi;
               r_lo <= w_fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
